// File: rtl/anton_neopixel_stream_if.sv
// Bus between the neopixel register block and the stream serialiser:
// pixel-buffer read port, control fields, and the status/serial outputs.
interface anton_neopixel_stream_if #(
    parameter int BUFFER_BITS = 13
);
    logic [BUFFER_BITS-1:0] pixelIndex;
    logic [7:0]             pixelByte;
    logic [12:0]            regMax;
    logic                   regCtrlLimit;
    logic                   regCtrlRun;
    logic                   regCtrl32bit;
    logic                   neoData;
    logic                   state;
    logic                   streamSyncOf;

    // Stream side: addresses the buffer and drives the wire/status.
    modport master (
        output pixelIndex, neoData, state, streamSyncOf,
        input  pixelByte, regMax, regCtrlLimit, regCtrlRun, regCtrl32bit
    );

    // Register-block side: supplies buffer bytes and control fields.
    modport slave (
        input  pixelIndex, neoData, state, streamSyncOf,
        output pixelByte, regMax, regCtrlLimit, regCtrlRun, regCtrl32bit
    );
endinterface

// File: rtl/anton_neopixel_stream.sv
// WS2812 serialiser: reads pixel bytes from the register-file buffer and
// sends them MSB first as 8-cycle high/low symbols, then a low latch gap.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 8191
`endif

module anton_neopixel_stream #(
    parameter int unsigned BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int unsigned RESET_CYCLES = 300
) (
    input  logic                    clk6mhz,
    input  logic                    syncReset,
    anton_neopixel_stream_if.master bus
);
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
    localparam int LW          = $clog2(RESET_CYCLES + 1);
    // Index arithmetic width: covers regMax and the buffer index plus a carry.
    localparam int IW          = ((BUFFER_BITS > 13) ? BUFFER_BITS : 13) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]             fsm_q, fsm_d;
    logic [BUFFER_BITS-1:0] pix_idx_q, pix_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [2:0]             cyc_cnt_q, cyc_cnt_d;
    logic [LW-1:0]          lat_cnt_q, lat_cnt_d;
    logic                   last_q, last_d;
    logic                   neo_q, neo_d;

    logic [IW-1:0] idx_w, next_w, last_idx_w;
    logic          is_last;
    logic          lat_done;

    // Next buffer index after the one being fetched, and whether that
    // fetched byte closes the frame (regMax clamped to the buffer end).
    always_comb begin
        idx_w  = IW'(pix_idx_q);
        next_w = idx_w + IW'(1);
        if (bus.regCtrl32bit && next_w[1:0] == 2'b11)
            next_w = idx_w + IW'(2);
        last_idx_w = IW'(BUFFER_END);
        if (bus.regCtrlLimit && IW'(bus.regMax) < IW'(BUFFER_END))
            last_idx_w = IW'(bus.regMax);
        is_last = (idx_w == last_idx_w) || (next_w > last_idx_w);
    end

    assign lat_done = (lat_cnt_q == LW'(RESET_CYCLES - 1));

    // Frame sequencing: byte fetch, bit/cycle counting and the latch gap.
    // The prefetch index only advances when more bytes follow, so it never
    // moves past the last index of the frame.
    always_comb begin
        fsm_d     = fsm_q;
        pix_idx_d = pix_idx_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        lat_cnt_d = lat_cnt_q;
        last_d    = last_q;
        case (fsm_q)
            S_IDLE: begin
                pix_idx_d = '0;
                if (bus.regCtrlRun) begin
                    shift_d   = bus.pixelByte;
                    bit_cnt_d = 3'd7;
                    cyc_cnt_d = 3'd0;
                    last_d    = is_last;
                    pix_idx_d = is_last ? pix_idx_q : next_w[BUFFER_BITS-1:0];
                    fsm_d     = S_DATA;
                end
            end
            S_DATA: begin
                cyc_cnt_d = cyc_cnt_q + 3'd1;
                if (cyc_cnt_q == 3'd7) begin
                    if (bit_cnt_q != 3'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else if (last_q) begin
                        fsm_d     = S_LATCH;
                        pix_idx_d = '0;
                        lat_cnt_d = '0;
                    end else begin
                        shift_d   = bus.pixelByte;
                        bit_cnt_d = 3'd7;
                        last_d    = is_last;
                        pix_idx_d = is_last ? pix_idx_q : next_w[BUFFER_BITS-1:0];
                    end
                end
            end
            S_LATCH: begin
                if (lat_done) begin
                    fsm_d     = S_IDLE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        // Wire level derived from next-state values so the registered
        // output lines up with the current symbol cycle, glitch-free.
        neo_d = (fsm_d == S_DATA) &&
                (cyc_cnt_d < (shift_d[7] ? 3'd5 : 3'd2));
    end

    // State registers with synchronous reset; reset aborts a frame silently.
    always_ff @(posedge clk6mhz) begin
        if (syncReset) begin
            fsm_q     <= S_IDLE;
            pix_idx_q <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            lat_cnt_q <= '0;
            last_q    <= 1'b0;
            neo_q     <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            pix_idx_q <= pix_idx_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            last_q    <= last_d;
            neo_q     <= neo_d;
        end
    end

    assign bus.pixelIndex   = pix_idx_q;
    assign bus.neoData      = neo_q;
    assign bus.state        = (fsm_q == S_DATA);
    assign bus.streamSyncOf = (fsm_q == S_LATCH) && lat_done;
endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Directed bench for the WS2812 serialiser: table of frame configurations
// checked cycle by cycle against a waveform built from the pixel bytes.
module tb_anton_neopixel_stream;
    localparam int BE   = 11;
    localparam int BB   = 4;
    localparam int RC   = 300;
    localparam int CAPN = 1100;

    logic clk6mhz = 1'b0;
    logic syncReset;
    always #5 clk6mhz = ~clk6mhz;

    anton_neopixel_stream_if #(.BUFFER_BITS(BB)) bus ();

    anton_neopixel_stream #(.BUFFER_END(BE), .RESET_CYCLES(RC)) dut (
        .clk6mhz  (clk6mhz),
        .syncReset(syncReset),
        .bus      (bus)
    );

    logic [7:0] mem [0:15];
    assign bus.pixelByte = mem[bus.pixelIndex];

    typedef struct {
        string       name;
        logic        lim;
        logic [12:0] rmax;
        logic        b32;
        int          n;
        int          seq [12];
    } vec_t;

    vec_t vecs [6];

    logic cap_neo [CAPN], cap_st [CAPN], cap_sync [CAPN];
    logic exp_neo [CAPN], exp_st [CAPN], exp_sync [CAPN];
    int   maxidx;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < CAPN; i++) begin
            exp_neo[i] = 1'b0; exp_st[i] = 1'b0; exp_sync[i] = 1'b0;
        end
    endtask

    // Expected wire: per bit 8 cycles, high 5 for a one and 2 for a zero.
    task automatic add_frame(input int start, input vec_t v);
        int pos;
        logic [7:0] b;
        pos = start;
        for (int j = 0; j < v.n; j++) begin
            b = mem[v.seq[j]];
            for (int k = 7; k >= 0; k--)
                for (int c = 0; c < 8; c++) begin
                    if (pos < CAPN) begin
                        exp_neo[pos] = (c < (b[k] ? 5 : 2));
                        exp_st[pos]  = 1'b1;
                    end
                    pos++;
                end
        end
        if (pos + RC - 1 < CAPN) exp_sync[pos + RC - 1] = 1'b1;
    endtask

    // Samples on falling edges starting now; drops run after sample drop_at.
    task automatic capture(input int len, input int drop_at);
        maxidx = 0;
        for (int i = 0; i < len; i++) begin
            cap_neo[i]  = bus.neoData;
            cap_st[i]   = bus.state;
            cap_sync[i] = bus.streamSyncOf;
            if (int'(bus.pixelIndex) > maxidx) maxidx = int'(bus.pixelIndex);
            if (i == drop_at) bus.regCtrlRun = 1'b0;
            @(negedge clk6mhz);
        end
    endtask

    task automatic compare(input string name, input int len);
        int en, es, ey, fn, fs, fy;
        en = 0; es = 0; ey = 0; fn = -1; fs = -1; fy = -1;
        for (int i = 0; i < len; i++) begin
            if (cap_neo[i] !== exp_neo[i])   begin if (en == 0) fn = i; en++; end
            if (cap_st[i] !== exp_st[i])     begin if (es == 0) fs = i; es++; end
            if (cap_sync[i] !== exp_sync[i]) begin if (ey == 0) fy = i; ey++; end
        end
        chk($sformatf("%s_neo_errs(first@%0d)", name, fn), en, 0);
        chk($sformatf("%s_state_errs(first@%0d)", name, fs), es, 0);
        chk($sformatf("%s_sync_errs(first@%0d)", name, fy), ey, 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the first DATA cycle.
    task automatic start(input vec_t v, input logic hold);
        bus.regCtrlLimit = v.lim;
        bus.regMax       = v.rmax;
        bus.regCtrl32bit = v.b32;
        bus.regCtrlRun   = 1'b1;
        @(negedge clk6mhz);
        if (!hold) bus.regCtrlRun = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int len;
        len = 64 * v.n + RC + 2;
        clear_exp();
        add_frame(0, v);
        start(v, 1'b0);
        capture(len, -1);
        compare(v.name, len);
        chk({v.name, "_max_index"}, maxidx, v.seq[v.n - 1]);
        chk({v.name, "_idle_index"}, int'(bus.pixelIndex), 0);
    endtask

    initial begin
        vec_t lp;
        mem = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E, 8'hC3, 8'h18,
                8'h5A, 8'hE7, 8'h01, 8'h80, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
        vecs[0] = '{"lim3",   1'b1, 13'd2,    1'b0, 3,  '{0,1,2,0,0,0,0,0,0,0,0,0}};
        vecs[1] = '{"rgbw8",  1'b1, 13'd7,    1'b1, 6,  '{0,1,2,4,5,6,0,0,0,0,0,0}};
        vecs[2] = '{"clamp",  1'b1, 13'h1FFF, 1'b0, 12, '{0,1,2,3,4,5,6,7,8,9,10,11}};
        vecs[3] = '{"one",    1'b1, 13'd0,    1'b0, 1,  '{0,0,0,0,0,0,0,0,0,0,0,0}};
        vecs[4] = '{"full32", 1'b0, 13'd3,    1'b1, 9,  '{0,1,2,4,5,6,8,9,10,0,0,0}};
        vecs[5] = '{"rgbw6",  1'b1, 13'd5,    1'b1, 5,  '{0,1,2,4,5,0,0,0,0,0,0,0}};

        bus.regCtrlRun = 1'b0; bus.regCtrlLimit = 1'b0;
        bus.regCtrl32bit = 1'b0; bus.regMax = '0;
        syncReset = 1'b1;
        repeat (3) @(negedge clk6mhz);
        chk("rst_neo",   int'(bus.neoData), 0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_sync",  int'(bus.streamSyncOf), 0);
        chk("rst_index", int'(bus.pixelIndex), 0);
        syncReset = 1'b0;
        @(negedge clk6mhz);

        for (int t = 0; t < 6; t++) run_vec(vecs[t]);

        // Looping: run held through the first frame, dropped in the second.
        lp = '{"loop", 1'b1, 13'd1, 1'b0, 2, '{0,1,0,0,0,0,0,0,0,0,0,0}};
        clear_exp();
        add_frame(0, lp);
        add_frame(128 + RC + 1, lp);
        start(lp, 1'b1);
        capture(1000, 430);
        compare("loop", 1000);
        chk("loop_gap_low",  int'(cap_neo[428]), 0);
        chk("loop_restart",  int'(cap_neo[429]), 1);

        // Reset mid-byte aborts with no latch or sync; run restarts at byte 0.
        start(vecs[0], 1'b0);
        capture(20, -1);
        syncReset = 1'b1;
        @(negedge clk6mhz);
        chk("abort_neo",   int'(bus.neoData), 0);
        chk("abort_state", int'(bus.state), 0);
        chk("abort_index", int'(bus.pixelIndex), 0);
        chk("abort_sync",  int'(bus.streamSyncOf), 0);
        syncReset = 1'b0;
        clear_exp();
        capture(350, -1);
        compare("abort_quiet", 350);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
